// File: rtl/stack_upstream_receiver.sv
// Stack-side receiver for the PE upstream bus: skid FIFO with headroom-based ready,
// SOP/EOP framing checker, completed-packet counter and sticky error flags.
module stack_upstream_receiver #(
    parameter int DATA_W     = 64,
    parameter int OOB_W      = 32,
    parameter int TYPE_W     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int SKID       = 4
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              pe__stu__valid,
    input  logic [1:0]        pe__stu__cntl,
    output logic              stu__pe__ready,
    input  logic [TYPE_W-1:0] pe__stu__type,
    input  logic [DATA_W-1:0] pe__stu__data,
    input  logic [OOB_W-1:0]  pe__stu__oob_data,
    output logic              stu__arb__valid,
    output logic [1:0]        stu__arb__cntl,
    input  logic              arb__stu__ready,
    output logic [TYPE_W-1:0] stu__arb__type,
    output logic [DATA_W-1:0] stu__arb__data,
    output logic [OOB_W-1:0]  stu__arb__oob_data,
    output logic [15:0]       stu__pkt_count,
    output logic              stu__err_framing,
    output logic              stu__err_overflow
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PW      = AW + 1;
    localparam int ENTRY_W = 2 + TYPE_W + DATA_W + OOB_W;

    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] SKID_P  = PW'(SKID);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    localparam logic [1:0] CNTL_MOP    = 2'b00;
    localparam logic [1:0] CNTL_SOP    = 2'b01;
    localparam logic [1:0] CNTL_EOP    = 2'b10;
    localparam logic [1:0] CNTL_SOPEOP = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
    logic               ready_r;
    state_t             state_r;
    state_t             state_next_s;
    logic [15:0]        pkt_count_r;
    logic               err_framing_r;
    logic               err_overflow_r;

    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          ovf_s;
    logic [PW-1:0] count_s;
    logic [PW-1:0] next_count_s;
    logic          ready_next_s;
    logic          frm_err_s;
    logic          pkt_done_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s   = !empty_s && arb__stu__ready;
    // A same-cycle pop frees the slot first, so a push into a full FIFO still lands.
    assign push_s  = pe__stu__valid && (!full_s || pop_s);
    assign ovf_s   = pe__stu__valid && full_s && !pop_s;

    assign count_s      = wr_ptr_r - rd_ptr_r;
    assign next_count_s = count_s + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    assign ready_next_s = ((DEPTH_P - next_count_s) > SKID_P);

    assign stu__pe__ready    = ready_r;
    assign stu__arb__valid   = !empty_s;
    assign {stu__arb__cntl, stu__arb__type, stu__arb__data, stu__arb__oob_data} =
        mem_r[rd_ptr_r[AW-1:0]];
    assign stu__pkt_count    = pkt_count_r;
    assign stu__err_framing  = err_framing_r;
    assign stu__err_overflow = err_overflow_r;

    // FIFO pointers and registered upstream ready
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            ready_r <= ready_next_s;
        end
    end

    // Beat storage; cleared on reset so the head fields read zero
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {pe__stu__cntl, pe__stu__type,
                                        pe__stu__data, pe__stu__oob_data};
        end
    end

    // Framing next-state: every valid beat is tracked, including dropped ones
    always_comb begin
        state_next_s = state_r;
        frm_err_s    = 1'b0;
        pkt_done_s   = 1'b0;
        if (pe__stu__valid) begin
            case (state_r)
                ST_IDLE: begin
                    case (pe__stu__cntl)
                        CNTL_SOP:    state_next_s = ST_IN_PKT;
                        CNTL_SOPEOP: pkt_done_s   = 1'b1;
                        CNTL_MOP:    frm_err_s    = 1'b1;
                        CNTL_EOP:    frm_err_s    = 1'b1;
                        default:     frm_err_s    = 1'b1;
                    endcase
                end
                ST_IN_PKT: begin
                    case (pe__stu__cntl)
                        CNTL_MOP: state_next_s = ST_IN_PKT;
                        CNTL_EOP: begin
                            state_next_s = ST_IDLE;
                            pkt_done_s   = 1'b1;
                        end
                        CNTL_SOP: begin
                            state_next_s = ST_IN_PKT;
                            frm_err_s    = 1'b1;
                        end
                        CNTL_SOPEOP: begin
                            state_next_s = ST_IDLE;
                            frm_err_s    = 1'b1;
                            pkt_done_s   = 1'b1;
                        end
                        default: frm_err_s = 1'b1;
                    endcase
                end
                default: state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Framing state, packet counter and sticky error flags
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_r        <= ST_IDLE;
            pkt_count_r    <= 16'd0;
            err_framing_r  <= 1'b0;
            err_overflow_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (pkt_done_s) begin
                pkt_count_r <= pkt_count_r + 16'd1;
            end
            if (frm_err_s) begin
                err_framing_r <= 1'b1;
            end
            if (ovf_s) begin
                err_overflow_r <= 1'b1;
            end
        end
    end

endmodule
